// File: rtl/mipi_lane_ctrl_if.sv
// -----------------------------------------------------------------------------
// mipi_lane_ctrl_if
// Lane-side signal bundle for one D-PHY data lane controller.
//   enable      : synchronous lane enable (low forces idle)
//   lp_p, lp_n  : raw LP comparator levels of the lane pins (asynchronous)
//   sync_found  : one-cycle pulse from the deserializer on sync byte alignment
//   termination : lane termination enable
//   hs_en       : deserializer HS receive enable
//   pkt_active  : high while a synced HS burst is in progress
//   sot_err     : one-cycle start-of-transmission error pulse
//   state       : current controller state code (debug)
// Modport slave is the controller view, master is the pin/datapath view.
// -----------------------------------------------------------------------------
interface mipi_lane_ctrl_if;
  logic       enable;
  logic       lp_p;
  logic       lp_n;
  logic       sync_found;
  logic       termination;
  logic       hs_en;
  logic       pkt_active;
  logic       sot_err;
  logic [2:0] state;

  modport slave (
    input  enable, lp_p, lp_n, sync_found,
    output termination, hs_en, pkt_active, sot_err, state
  );

  modport master (
    output enable, lp_p, lp_n, sync_found,
    input  termination, hs_en, pkt_active, sot_err, state
  );
endinterface

// File: rtl/mipi_lane_ctrl.sv
// -----------------------------------------------------------------------------
// mipi_lane_ctrl
// D-PHY lane-state controller for one CSI-2 data lane. Synchronizes the LP
// pin levels, detects the LP-11 -> LP-01 -> LP-00 start-of-transmission
// sequence, enables termination, waits the HS-settle time, arms the HS
// deserializer and tracks the burst until the lane returns to LP-11.
// Ports:
//   bit_clk : sole clock
//   reset   : asynchronous active-high reset
//   lane    : mipi_lane_ctrl_if.slave bundle (enable, lp_p, lp_n, sync_found
//             in; termination, hs_en, pkt_active, sot_err, state out)
// State codes: STOP=0 HS_RQST=1 HS_PREP=2 HS_SYNC=3 HS_DATA=4 WAIT_STOP=5.
// -----------------------------------------------------------------------------
module mipi_lane_ctrl #(
  parameter int SETTLE_CYCLES = 15,
  parameter int LP11_MIN      = 4,
  parameter int SYNC_TIMEOUT  = 64,
  parameter int CNT_W         = 8
) (
  input  logic            bit_clk,
  input  logic            reset,
  mipi_lane_ctrl_if.slave lane
);

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_HS_RQST   = 3'd1,
    ST_HS_PREP   = 3'd2,
    ST_HS_SYNC   = 3'd3,
    ST_HS_DATA   = 3'd4,
    ST_WAIT_STOP = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LP11_SAT    = CNT_W'(LP11_MIN);
  localparam logic [CNT_W-1:0] LP11_LAST   = CNT_W'(LP11_MIN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Saturating increment: counters must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // 2-FF synchronizer on the asynchronous LP comparator levels, {p,n}.
  // ---------------------------------------------------------------------------
  logic [1:0] lp_meta_q;
  logic [1:0] lp_sync_q;

  always_ff @(posedge bit_clk or posedge reset) begin
    if (reset) begin
      lp_meta_q <= 2'b00;
      lp_sync_q <= 2'b00;
    end else begin
      lp_meta_q <= {lane.lp_p, lane.lp_n};
      lp_sync_q <= lp_meta_q;
    end
  end

  logic lp_is_11;
  logic lp_is_01;
  logic lp_is_00;
  logic lp_is_10;

  assign lp_is_11 = (lp_sync_q == 2'b11);
  assign lp_is_01 = (lp_sync_q == 2'b01);
  assign lp_is_00 = (lp_sync_q == 2'b00);
  assign lp_is_10 = (lp_sync_q == 2'b10);

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [CNT_W-1:0] lp11_q,   lp11_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] tmo_q,    tmo_d;
  logic             termination_q, termination_d;
  logic             hs_en_q,       hs_en_d;
  logic             pkt_active_q,  pkt_active_d;
  logic             sot_err_q,     sot_err_d;
  logic             stop_ok;

  // Stop state is declared on the sample that completes the LP-11 run, so the
  // count seen here is one short of LP11_MIN. Once saturated it stays false,
  // which is harmless: every state that reacts to it is left on that edge.
  assign stop_ok = (lp11_q == LP11_LAST) && lp_is_11;

  always_ff @(posedge bit_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_WAIT_STOP;
      lp11_q        <= '0;
      settle_q      <= '0;
      tmo_q         <= '0;
      termination_q <= 1'b0;
      hs_en_q       <= 1'b0;
      pkt_active_q  <= 1'b0;
      sot_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lp11_q        <= lp11_d;
      settle_q      <= settle_d;
      tmo_q         <= tmo_d;
      termination_q <= termination_d;
      hs_en_q       <= hs_en_d;
      pkt_active_q  <= pkt_active_d;
      sot_err_q     <= sot_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Outputs are decoded from the next state so that they
  // are registered and change on the same edge as state_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    tmo_d     = tmo_q;
    sot_err_d = 1'b0;
    lp11_d    = lp_is_11 ? ((lp11_q >= LP11_SAT) ? lp11_q : sat_inc(lp11_q)) : '0;

    if (!lane.enable) begin
      // Disabled lane: idle in WAIT_STOP with everything cleared, silently.
      state_d  = ST_WAIT_STOP;
      lp11_d   = '0;
      settle_d = '0;
      tmo_d    = '0;
    end else begin
      case (state_q)
        ST_WAIT_STOP: begin
          if (stop_ok) begin
            state_d = ST_STOP;
          end
        end

        ST_STOP: begin
          if (lp_is_01) begin
            state_d = ST_HS_RQST;
          end else if (lp_is_10) begin
            // Escape mode entry is not supported; drop out without an error.
            state_d = ST_WAIT_STOP;
          end else if (lp_is_00) begin
            state_d   = ST_WAIT_STOP;
            sot_err_d = 1'b1;
          end
        end

        ST_HS_RQST: begin
          if (lp_is_00) begin
            state_d  = ST_HS_PREP;
            settle_d = '0;
          end else if (lp_is_11) begin
            state_d = ST_STOP;
          end else if (lp_is_10) begin
            state_d   = ST_WAIT_STOP;
            sot_err_d = 1'b1;
          end
        end

        ST_HS_PREP: begin
          if (stop_ok) begin
            state_d   = ST_STOP;
            sot_err_d = 1'b1;
          end else if (settle_q == SETTLE_LAST) begin
            state_d = ST_HS_SYNC;
            tmo_d   = '0;
          end else begin
            settle_d = sat_inc(settle_q);
          end
        end

        ST_HS_SYNC: begin
          // Lane stop beats a late sync byte; a sync byte beats the timeout.
          if (stop_ok) begin
            state_d   = ST_STOP;
            sot_err_d = 1'b1;
          end else if (lane.sync_found) begin
            state_d = ST_HS_DATA;
          end else if (tmo_q == TMO_LAST) begin
            state_d   = ST_WAIT_STOP;
            sot_err_d = 1'b1;
          end else begin
            tmo_d = sat_inc(tmo_q);
          end
        end

        ST_HS_DATA: begin
          if (stop_ok) begin
            state_d = ST_STOP;
          end
        end

        default: begin
          state_d = ST_WAIT_STOP;
        end
      endcase
    end

    termination_d = (state_d == ST_HS_PREP) || (state_d == ST_HS_SYNC) ||
                    (state_d == ST_HS_DATA);
    hs_en_d       = (state_d == ST_HS_SYNC) || (state_d == ST_HS_DATA);
    pkt_active_d  = (state_d == ST_HS_DATA);
  end

  assign lane.termination = termination_q;
  assign lane.hs_en       = hs_en_q;
  assign lane.pkt_active  = pkt_active_q;
  assign lane.sot_err     = sot_err_q;
  assign lane.state       = state_q;

endmodule

// File: doc/mipi_lane_ctrl.md
# mipi_lane_ctrl

D-PHY lane-state controller for one MIPI CSI-2 data lane on the camera input path. It watches the lane's low-power (LP) levels, detects the start-of-transmission sequence LP-11 → LP-01 → LP-00, and enables the lane termination. After the HS-settle time it arms the HS deserializer and tracks the burst until the lane returns to LP-11. One instance sits per lane between the lane pins and the MIPI receiver datapath. Its `termination` output drives the lane's termination tristate control.

## Interface
Parameters:
- `SETTLE_CYCLES`, 15: HS-settle length in `bit_clk` cycles (150 ns at 100 MHz).
- `LP11_MIN`, 4: consecutive synced LP-11 samples needed to declare stop state.
- `SYNC_TIMEOUT`, 64: cycles allowed in HS_SYNC before the sync byte must be found.
- `CNT_W`, 8: counter width. Must hold the largest of the three parameters above.

Ports:
- `bit_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  synchronous lane enable. Low forces idle.
- `lp_p`  in  1  LP comparator level of the lane P pin. Asynchronous.
- `lp_n`  in  1  LP comparator level of the lane N pin. Asynchronous.
- `sync_found`  in  1  single-cycle pulse from the deserializer when the sync byte 0xB8 is aligned.
- `termination`  out  1  lane termination enable.
- `hs_en`  out  1  deserializer HS receive enable.
- `pkt_active`  out  1  high while a synced HS burst is in progress.
- `sot_err`  out  1  single-cycle start-of-transmission error pulse.
- `state`  out  3  current state code, for debug.

## Operation
- `lp_p` and `lp_n` each pass through a 2-FF synchronizer. All decisions use the synced pair, written {p,n}.
- `lp11_cnt` counts consecutive synced LP-11 samples. It saturates at `LP11_MIN` and clears on any other level. `stop_ok` = (`lp11_cnt` == `LP11_MIN`-1 and the current sample is LP-11).
- States and codes: STOP=0, HS_RQST=1, HS_PREP=2, HS_SYNC=3, HS_DATA=4, WAIT_STOP=5.
- Priority, applied first: `enable`=0 → WAIT_STOP. All counters clear, all outputs are 0, and no `sot_err` is raised.
- WAIT_STOP: `stop_ok` → STOP. Otherwise stay.
- STOP:
  - LP-01 → HS_RQST.
  - LP-10 → WAIT_STOP, no error (escape mode is unsupported).
  - LP-00 → WAIT_STOP with `sot_err`.
- HS_RQST:
  - LP-01 → stay.
  - LP-00 → HS_PREP; settle counter clears.
  - LP-11 → STOP.
  - LP-10 → WAIT_STOP with `sot_err`.
- HS_PREP: settle counter increments each cycle. At count SETTLE_CYCLES-1 → HS_SYNC, with the timeout counter cleared. `stop_ok` → STOP with `sot_err`.
- HS_SYNC:
  - `sync_found` → HS_DATA.
  - Timeout counter reaches SYNC_TIMEOUT-1 without sync → WAIT_STOP with `sot_err`.
  - `stop_ok` → STOP with `sot_err`.
- HS_DATA: `stop_ok` → STOP (normal end of transmission, no error).
- Output decode:
  - `termination` = 1 in HS_PREP, HS_SYNC and HS_DATA.
  - `hs_en` = 1 in HS_SYNC and HS_DATA.
  - `pkt_active` = 1 in HS_DATA.
  - `state` = code of the current state.
- Simultaneous events, in priority order:
  - `enable`=0 beats everything.
  - `stop_ok` beats `sync_found`.
  - `sync_found` beats the timeout.
- Counters are `CNT_W` bits wide and saturating. They never wrap.

## Timing
- Reset values: state = WAIT_STOP (5). `termination`, `hs_en`, `pkt_active` and `sot_err` are all 0. All counters and synchronizer flops are 0.
- All outputs are registered and update on the same `bit_clk` edge as `state`.
- Pin-to-state latency is 3 edges: 2 synchronizer edges plus 1 state edge. Example: LP-00 at the pins → `termination`=1 on the 3rd rising edge after the change.
- HS_PREP lasts exactly `SETTLE_CYCLES` cycles. `hs_en` rises `SETTLE_CYCLES` cycles after `termination`.
- `sync_found` sampled at edge t → `pkt_active`=1 after edge t.
- `sot_err` is high for exactly one cycle, in the first cycle after the offending transition.
- From reset, the lane needs `LP11_MIN` synced LP-11 samples before it reaches STOP. This prevents joining a burst mid-stream.
- A reset asserted mid-burst clears `termination`, `hs_en` and `pkt_active` immediately, without waiting for a clock edge.

## Test plan
- Reset, then hold LP-11 for 10 cycles → `state` goes 5→0 after 2+4 edges; all outputs stay 0.
- Drive LP-11, LP-01, LP-00, then pulse `sync_found` 5 cycles after `hs_en` rises:
  - `termination`=1 3 edges after LP-00.
  - `hs_en`=1 exactly 15 cycles later.
  - `pkt_active`=1 one cycle after the pulse.
  - Then drive LP-11 for 4 samples → back to STOP, `sot_err` never asserted.
- Same sequence but no `sync_found` → after 64 cycles in HS_SYNC, `sot_err` pulses once, `state`=5, `termination`=`hs_en`=0.
- From STOP drive LP-00 directly → one `sot_err` pulse and `state`=5. From STOP drive LP-10 → `state`=5 with no `sot_err`.
- In HS_DATA, deassert `enable` → `state`=5 and outputs 0 on the next edge, no `sot_err`. Separately, assert `reset` mid-HS_DATA → outputs 0 without a clock edge.
- In HS_SYNC, assert `sync_found` in the same cycle that `stop_ok` becomes true → `state`=STOP and `sot_err`=1. Separately, assert `sync_found` on the timeout terminal cycle → HS_DATA with no error.
